// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter steering one valid/ready stream through a 2:1 select.
// Grants are held per packet (released on last) with a beat cap that forces rotation.
module mux2_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req0_last,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             req1_last,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             sel,
    output logic [1:0]       grant
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            last_served;

    logic [1:0]      vld;
    logic [1:0]      lst;
    logic            owner;
    logic            cur_valid;
    logic            cur_last;
    logic            xfer;
    logic [CW-1:0]   cnt_inc;
    logic            rel;

    assign vld = {req1_valid, req0_valid};
    assign lst = {req1_last, req0_last};

    assign grant     = {state == GNT1, state == GNT0};
    assign owner     = (state == GNT1);
    assign cur_valid = vld[owner];
    assign cur_last  = lst[owner];

    // Readies and valid are gated by rst so nothing handshakes during a reset cycle.
    assign out_valid  = !rst && (|grant) && cur_valid;
    assign req0_ready = !rst && grant[0] && out_ready;
    assign req1_ready = !rst && grant[1] && out_ready;

    assign out_data = sel ? req1_data : req0_data;
    assign out_last = (sel ? req1_last : req0_last) & (|grant);

    assign xfer    = out_valid && out_ready;
    assign cnt_inc = cnt + 1'b1;
    // A last beat that also hits the cap is still one release.
    assign rel     = xfer && (cur_last || (cnt_inc == CW'(MAX_BURST)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sel         <= 1'b0;
            cnt         <= '0;
            last_served <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (vld == 2'b11) begin
                        if (last_served) begin
                            state <= GNT0;
                            sel   <= 1'b0;
                        end else begin
                            state <= GNT1;
                            sel   <= 1'b1;
                        end
                    end else if (vld[0]) begin
                        state <= GNT0;
                        sel   <= 1'b0;
                    end else if (vld[1]) begin
                        state <= GNT1;
                        sel   <= 1'b1;
                    end
                end
                GNT0, GNT1: begin
                    if (rel) begin
                        cnt         <= '0;
                        last_served <= owner;
                        // Hand straight to a waiting peer to avoid an idle bubble.
                        if (vld[!owner]) begin
                            state <= owner ? GNT0 : GNT1;
                            sel   <= !owner;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (xfer) begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: per-cycle comparison against a transaction-level arbitration
// model, plus literal beat-order expectations for a few hand-worked scenarios.
module tb_mux2_rr_arbiter;
    localparam int WIDTH = 8;
    localparam int MB    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0, req0_last = 1'b0;
    logic [WIDTH-1:0] req0_data = '0;
    logic             req1_valid = 1'b0, req1_last = 1'b0;
    logic [WIDTH-1:0] req1_data = '0;
    logic             out_ready = 1'b0;
    logic             req0_ready, req1_ready, out_valid, out_last, sel;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       grant;

    mux2_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .sel(sel), .grant(grant)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: who owns the channel (-1 none), beats sent in this grant, who was served last.
    int own   = -1;
    int beats = 0;
    int ls    = 1;
    bit selm  = 1'b0;
    bit acc0, acc1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare this cycle's outputs against the model, then advance the model across one edge.
    task automatic step();
        logic [1:0]       eg;
        logic             ev, e0, e1, el;
        logic [WIDTH-1:0] ed;
        bit               x, cl, ov;
        #1;
        eg = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
        ev = !rst && ((own == 0 && req0_valid) || (own == 1 && req1_valid));
        e0 = !rst && own == 0 && out_ready;
        e1 = !rst && own == 1 && out_ready;
        ed = selm ? req1_data : req0_data;
        el = (selm ? req1_last : req0_last) && own >= 0;
        chk("grant", grant, eg);
        chk("out_valid", out_valid, ev);
        chk("req0_ready", req0_ready, e0);
        chk("req1_ready", req1_ready, e1);
        chk("out_data", out_data, ed);
        chk("out_last", out_last, el);
        chk("sel", sel, selm);
        chk("cnt", dut.cnt, beats);
        x    = ev && out_ready;
        acc0 = x && own == 0;
        acc1 = x && own == 1;
        cl   = (own == 1) ? req1_last : req0_last;
        if (rst) begin
            own = -1; beats = 0; ls = 1; selm = 1'b0;
        end else if (own < 0) begin
            if (req0_valid && req1_valid) own = (ls == 0) ? 1 : 0;
            else if (req0_valid)          own = 0;
            else if (req1_valid)          own = 1;
            if (own >= 0) selm = (own == 1);
        end else if (x) begin
            beats++;
            if (cl || beats == MB) begin
                ls    = own;
                beats = 0;
                ov    = (own == 0) ? req1_valid : req0_valid;
                if (ov) begin
                    own  = 1 - own;
                    selm = (own == 1);
                end else begin
                    own = -1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_last = 1'b0; req1_last = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // Both requesters stream packets of fixed length (0 = never last); beats collected in order.
    task automatic drive_pkts(input int cycles, input int len0, input int len1,
                              output logic [WIDTH-1:0] got[$]);
        int b0 = 0, b1 = 0;
        got = {};
        out_ready = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            req0_data  = WIDTH'(b0);
            req1_data  = WIDTH'(8'h80 | b1);
            req0_last  = (len0 > 0) && (b0 % len0 == len0 - 1);
            req1_last  = (len1 > 0) && (b1 % len1 == len1 - 1);
            #1;
            if (out_valid && out_ready) got.push_back(out_data);
            step();
            if (acc0) b0++;
            if (acc1) b1++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] got[$];
        logic [WIDTH-1:0] exp2[6];
        logic [WIDTH-1:0] exp3[10];
        int s0, s1;
        exp2 = '{8'h00, 8'h01, 8'h80, 8'h81, 8'h02, 8'h03};
        exp3 = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h80, 8'h04, 8'h05, 8'h06, 8'h07, 8'h81};

        // Single 3-beat packet from requester 0.
        out_ready = 1'b1;
        do_reset();
        req0_valid = 1'b1; req0_data = 8'hA0; req0_last = 1'b0;
        #1 chk("t1_idle_grant", grant, 2'b00);
        step();
        #1 chk("t1_grant_c1", grant, 2'b01);
        chk("t1_A0", out_data, 8'hA0);
        step();
        req0_data = 8'hA1;
        #1 chk("t1_A1", out_data, 8'hA1);
        step();
        req0_data = 8'hA2; req0_last = 1'b1;
        #1 chk("t1_A2", out_data, 8'hA2);
        chk("t1_last", out_last, 1'b1);
        step();
        req0_valid = 1'b0; req0_last = 1'b0;
        #1 chk("t1_idle_c4", grant, 2'b00);
        step();

        // Alternating 2-beat packets, no idle gap.
        do_reset();
        drive_pkts(7, 2, 2, got);
        chk("t2_count", got.size(), 6);
        foreach (exp2[i]) if (i < got.size()) chk("t2_order", got[i], exp2[i]);

        // Burst cap forces rotation of an endless req0 packet.
        do_reset();
        drive_pkts(11, 0, 1, got);
        chk("t3_count", got.size(), 10);
        foreach (exp3[i]) if (i < got.size()) chk("t3_order", got[i], exp3[i]);

        // Reset during a req1 packet, then requester 0 wins.
        do_reset();
        req1_valid = 1'b1; req1_data = 8'h55; req1_last = 1'b0;
        step();
        #1 chk("t5_grant1", grant, 2'b10);
        step();
        rst = 1'b1; req0_valid = 1'b1;
        #1 chk("t5_rst_r1", req1_ready, 1'b0);
        chk("t5_rst_ov", out_valid, 1'b0);
        step();
        rst = 1'b0;
        #1 chk("t5_idle", grant, 2'b00);
        step();
        #1 chk("t5_req0_first", grant, 2'b01);
        step();

        // Randomized traffic with stalls, valid drops and occasional reset.
        do_reset();
        s0 = 0; s1 = 0;
        req0_data = 8'h00; req1_data = 8'h80;
        req0_last = 1'b0; req1_last = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(199) == 0);
            req0_valid = ($urandom_range(9) < 7);
            req1_valid = ($urandom_range(9) < 6);
            out_ready  = ($urandom_range(3) != 0);
            step();
            if (acc0) begin
                s0++;
                req0_data = WIDTH'(s0 & 8'h7f);
                req0_last = ($urandom_range(5) == 0);
            end
            if (acc1) begin
                s1++;
                req1_data = WIDTH'(8'h80 | (s1 & 8'h7f));
                req1_last = ($urandom_range(3) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
